master_sequencer_n: RTL and testbench

- Parametrised master controller that sequences one of N_CH subordinate state machines.
- A button press selects a channel, enables it and monitors its packed state bus until that channel reports its completion code.
- Also provides:
  - a watchdog timeout to a FAULT state;
  - an abort/return-to-idle path;
  - registered status flags for the display and top-level logic.
- Sits at the top level above the sub-machines, replacing the fixed three-button, two-channel master.

---
 rtl/master_sequencer_n.sv | 205 ++++++++++++++++++++
 tb/tb_master_sequencer_n.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/master_sequencer_n.sv
// -----------------------------------------------------------------------------
// master_sequencer_n
//
// Top-level controller that runs one of N_CH subordinate state machines at a
// time. A rising edge on a channel-select button picks a channel (lowest index
// wins on simultaneous presses). The sequencer enables that channel for one ARM
// cycle, then watches its packed state slice until it equals the channel's
// completion code. A watchdog moves to FAULT if the channel runs too long, and
// an abort button returns to idle from RUN, DONE or FAULT.
//
// Ports
//   CLK             system clock, rising edge
//   RESET           synchronous, active-high reset
//   BTN_SEL         debounced channel request buttons, bit i -> channel i
//   BTN_ABORT       debounced abort / acknowledge button
//   STATE_IN        packed sub-machine states, channel i at [i*SW +: SW]
//   TARGET_STATE    packed completion codes, channel i at [i*SW +: SW]
//   MASTER_CONTROL  index of the selected channel (0 in IDLE)
//   CH_EN           one-hot enable of the selected channel during ARM/RUN
//   ACTIVE          high in ARM and RUN
//   DONE            high while in DONE
//   DONE_PULSE      one-cycle pulse on entry to DONE
//   FAULT           high while in FAULT
//
// All outputs are registered decodes of the current state, so they appear
// one clock after the state register changes.
// -----------------------------------------------------------------------------
module master_sequencer_n #(
    parameter int N_CH           = 4,
    parameter int SW             = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N_CH-1:0]      BTN_SEL,
    input  logic                 BTN_ABORT,
    input  logic [N_CH*SW-1:0]   STATE_IN,
    input  logic [N_CH*SW-1:0]   TARGET_STATE,
    output logic [CH_W-1:0]      MASTER_CONTROL,
    output logic [N_CH-1:0]      CH_EN,
    output logic                 ACTIVE,
    output logic                 DONE,
    output logic                 DONE_PULSE,
    output logic                 FAULT
);

    // Timer is wide enough to hold TIMEOUT_CYCLES; at least one bit so the
    // timeout-disabled build still has a legal register.
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE,
        S_FLT
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CH_W-1:0]   r_sel;
    logic [TW-1:0]     r_timer;
    logic [N_CH-1:0]   r_sel_prev;
    logic              r_abort_prev;

    logic [N_CH-1:0]   w_sel_rise;
    logic              w_sel_any;
    logic [CH_W-1:0]   w_sel_idx;
    logic              w_abort_rise;
    logic [SW-1:0]     w_cur_state;
    logic [SW-1:0]     w_cur_target;
    logic              w_match;
    logic              w_timeout;

    logic [CH_W-1:0]   w_master_control;
    logic [N_CH-1:0]   w_ch_en;
    logic              w_active;
    logic              w_done;
    logic              w_done_pulse;
    logic              w_fault;

    // ------------------------------------------------------------------
    // Button edge detection and channel decode
    // ------------------------------------------------------------------
    assign w_sel_rise   = BTN_SEL & ~r_sel_prev;
    assign w_sel_any    = |w_sel_rise;
    assign w_abort_rise = BTN_ABORT & ~r_abort_prev;

    // Scan from the top down so the lowest rising bit is the last to write.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        w_sel_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_sel_rise[i]) begin
                w_sel_idx = CH_W'(i);
            end
        end
    end

    // Mux out the selected channel's state and completion code.
    always_comb begin
        w_cur_state  = '0;
        w_cur_target = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_sel == CH_W'(i)) begin
                w_cur_state  = STATE_IN[i*SW +: SW];
                w_cur_target = TARGET_STATE[i*SW +: SW];
            end
        end
    end

    assign w_match   = (w_cur_state == w_cur_target);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_timer == T_LAST);

    // ------------------------------------------------------------------
    // State register, selected channel, watchdog timer, edge history
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this edge.
        if (RESET) begin
            r_state      <= S_IDLE;
            r_sel        <= '0;
            r_timer      <= '0;
            // Load current button levels so a button held through reset
            // is not seen as a fresh press.
            r_sel_prev   <= BTN_SEL;
            r_abort_prev <= BTN_ABORT;
        end else begin
            r_state      <= w_next_state;
            r_sel_prev   <= BTN_SEL;
            r_abort_prev <= BTN_ABORT;

            if (r_state == S_IDLE && w_sel_any) begin
                r_sel <= w_sel_idx;
            end

            // Cleared in ARM; counts while RUN continues; saturates.
            if (r_state == S_ARM) begin
                r_timer <= '0;
            end else if (r_state == S_RUN && w_next_state == S_RUN && r_timer != '1) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (w_sel_any)    w_next_state = S_ARM;
            S_ARM:                    w_next_state = S_RUN;
            S_RUN: begin
                // Abort beats completion, completion beats timeout.
                if (w_abort_rise)     w_next_state = S_IDLE;
                else if (w_match)     w_next_state = S_DONE;
                else if (w_timeout)   w_next_state = S_FLT;
            end
            S_DONE: if (w_abort_rise) w_next_state = S_IDLE;
            S_FLT:  if (w_abort_rise) w_next_state = S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode of the current state
    // ------------------------------------------------------------------
    always_comb begin
        w_active         = (r_state == S_ARM) || (r_state == S_RUN);
        w_done           = (r_state == S_DONE);
        w_fault          = (r_state == S_FLT);
        // DONE is the registered copy of the previous cycle's state, so a
        // low DONE here marks the first cycle spent in S_DONE.
        w_done_pulse     = (r_state == S_DONE) && !DONE;
        w_master_control = (r_state == S_IDLE) ? '0 : r_sel;
        w_ch_en          = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_ch_en[i] = w_active && (r_sel == CH_W'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            MASTER_CONTROL <= '0;
            CH_EN          <= '0;
            ACTIVE         <= 1'b0;
            DONE           <= 1'b0;
            DONE_PULSE     <= 1'b0;
            FAULT          <= 1'b0;
        end else begin
            MASTER_CONTROL <= w_master_control;
            CH_EN          <= w_ch_en;
            ACTIVE         <= w_active;
            DONE           <= w_done;
            DONE_PULSE     <= w_done_pulse;
            FAULT          <= w_fault;
        end
    end

endmodule

// File: tb/tb_master_sequencer_n.sv
// -----------------------------------------------------------------------------
// tb_master_sequencer_n
//
// Four instances share one stimulus bus:
//   0: N_CH=4, TIMEOUT_CYCLES=1000  (main behaviour)
//   1: N_CH=4, TIMEOUT_CYCLES=8     (watchdog)
//   2: N_CH=4, TIMEOUT_CYCLES=0     (watchdog disabled)
//   3: N_CH=2, TIMEOUT_CYCLES=1000  (narrow build, low bits of the bus)
// Expected outputs are queued with the cycle they are due; a negedge monitor
// pops and compares them against the named instance.
// Output vector layout: {MASTER_CONTROL[3:0], CH_EN[3:0], ACTIVE, DONE,
// DONE_PULSE, FAULT}, zero-extended for narrow fields.
// -----------------------------------------------------------------------------
module tb_master_sequencer_n;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst;
    logic [3:0]  btn_sel;
    logic        btn_abort;
    logic [15:0] state_in;
    logic [15:0] target;

    logic [1:0] mc0, mc1, mc2;
    logic [0:0] mc3;
    logic [3:0] en0, en1, en2;
    logic [1:0] en3;
    logic act0, act1, act2, act3;
    logic dn0, dn1, dn2, dn3;
    logic dp0, dp1, dp2, dp3;
    logic ft0, ft1, ft2, ft3;

    master_sequencer_n #(.N_CH(4), .SW(4), .TIMEOUT_CYCLES(1000)) dut0 (
        .CLK(CLK), .RESET(rst), .BTN_SEL(btn_sel), .BTN_ABORT(btn_abort),
        .STATE_IN(state_in), .TARGET_STATE(target),
        .MASTER_CONTROL(mc0), .CH_EN(en0), .ACTIVE(act0), .DONE(dn0),
        .DONE_PULSE(dp0), .FAULT(ft0));

    master_sequencer_n #(.N_CH(4), .SW(4), .TIMEOUT_CYCLES(8)) dut1 (
        .CLK(CLK), .RESET(rst), .BTN_SEL(btn_sel), .BTN_ABORT(btn_abort),
        .STATE_IN(state_in), .TARGET_STATE(target),
        .MASTER_CONTROL(mc1), .CH_EN(en1), .ACTIVE(act1), .DONE(dn1),
        .DONE_PULSE(dp1), .FAULT(ft1));

    master_sequencer_n #(.N_CH(4), .SW(4), .TIMEOUT_CYCLES(0)) dut2 (
        .CLK(CLK), .RESET(rst), .BTN_SEL(btn_sel), .BTN_ABORT(btn_abort),
        .STATE_IN(state_in), .TARGET_STATE(target),
        .MASTER_CONTROL(mc2), .CH_EN(en2), .ACTIVE(act2), .DONE(dn2),
        .DONE_PULSE(dp2), .FAULT(ft2));

    master_sequencer_n #(.N_CH(2), .SW(4), .TIMEOUT_CYCLES(1000)) dut3 (
        .CLK(CLK), .RESET(rst), .BTN_SEL(btn_sel[1:0]), .BTN_ABORT(btn_abort),
        .STATE_IN(state_in[7:0]), .TARGET_STATE(target[7:0]),
        .MASTER_CONTROL(mc3), .CH_EN(en3), .ACTIVE(act3), .DONE(dn3),
        .DONE_PULSE(dp3), .FAULT(ft3));

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        string       tag;
        int          due;
        int          dut;
        logic [11:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge CLK) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [11:0] pk(input int mc, input logic [3:0] en,
                                       input logic a, input logic d,
                                       input logic p, input logic f);
        return {4'(mc), en, a, d, p, f};
    endfunction

    function automatic logic [11:0] get_obs(input int id);
        case (id)
            0:       return {2'b00, mc0, en0, act0, dn0, dp0, ft0};
            1:       return {2'b00, mc1, en1, act1, dn1, dp1, ft1};
            2:       return {2'b00, mc2, en2, act2, dn2, dp2, ft2};
            default: return {3'b000, mc3, 2'b00, en3, act3, dn3, dp3, ft3};
        endcase
    endfunction

    // Queue an expectation for instance id, dly clock edges from now.
    task automatic expect_out(input string tag, input int id, input int dly, input logic [11:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.due = cyc + dly;
        it.dut = id;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    always @(negedge CLK) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                check(sb_q[i].tag, 32'(get_obs(sb_q[i].dut)), 32'(sb_q[i].exp));
                sb_q.delete(i);
            end
        end
    end

    // Advance n rising edges and settle just past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    localparam logic [11:0] ZERO = 12'h000;

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        btn_sel   = 4'b0100;
        btn_abort = 1'b0;
        state_in  = 16'h0000;
        target    = 16'hFFFF;

        // Reset with channel 2 held: no ARM until released and pressed again.
        tick(3);
        for (int id = 0; id < 4; id++) expect_out("reset_zero", id, 0, ZERO);
        rst = 1'b0;
        expect_out("held_no_arm_1", 0, 1, ZERO);
        expect_out("held_no_arm_2", 0, 2, ZERO);
        expect_out("held_no_arm_3", 0, 3, ZERO);
        tick(4);
        btn_sel = 4'b0000;
        tick(2);
        btn_sel = 4'b0100;
        expect_out("arm_ch2", 0, 2, pk(2, 4'b0100, 1, 0, 0, 0));
        expect_out("run_ch2", 0, 3, pk(2, 4'b0100, 1, 0, 0, 0));
        tick(4);

        // Simultaneous presses resolve low; a press during RUN is ignored.
        btn_sel = 4'b0000;
        do_reset();
        tick(1);
        btn_sel = 4'b1010;
        expect_out("simul_lowest", 0, 2, pk(1, 4'b0010, 1, 0, 0, 0));
        tick(3);
        btn_sel = 4'b0000;
        tick(1);
        btn_sel = 4'b1000;
        expect_out("sel_ignored_run_a", 0, 2, pk(1, 4'b0010, 1, 0, 0, 0));
        expect_out("sel_ignored_run_b", 0, 3, pk(1, 4'b0010, 1, 0, 0, 0));
        tick(4);
        btn_sel = 4'b0000;

        // Channel 1 walks its state 0..7; target 7.
        target   = 16'hFF7F;
        state_in = 16'h0000;
        do_reset();
        tick(1);
        btn_sel = 4'b0010;
        tick(2);
        for (int v = 0; v < 7; v++) begin
            state_in[7:4] = 4'(v);
            tick(1);
        end
        state_in[7:4] = 4'h7;
        expect_out("pre_done_active", 0, 1, pk(1, 4'b0010, 1, 0, 0, 0));
        expect_out("done_entry",      0, 2, pk(1, 4'b0000, 0, 1, 1, 0));
        expect_out("pulse_once",      0, 3, pk(1, 4'b0000, 0, 1, 0, 0));
        expect_out("done_sticky",     0, 6, pk(1, 4'b0000, 0, 1, 0, 0));
        tick(8);
        btn_abort = 1'b1;
        expect_out("abort_hold_done", 0, 1, pk(1, 4'b0000, 0, 1, 0, 0));
        expect_out("abort_to_idle",   0, 2, ZERO);
        tick(4);
        btn_abort = 1'b0;
        btn_sel   = 4'b0000;
        state_in  = 16'h0000;

        // Abort and match in the same RUN cycle: abort wins.
        do_reset();
        tick(1);
        btn_sel = 4'b0010;
        tick(4);
        btn_abort     = 1'b1;
        state_in[7:4] = 4'h7;
        expect_out("abort_run_active", 0, 1, pk(1, 4'b0010, 1, 0, 0, 0));
        expect_out("abort_beats_match", 0, 2, ZERO);
        expect_out("no_done_after_a", 0, 3, ZERO);
        expect_out("no_done_after_b", 0, 5, ZERO);
        tick(6);
        btn_abort = 1'b0;
        btn_sel   = 4'b0000;
        state_in  = 16'h0000;

        // Reset while RUN timer is 5.
        target = 16'hFFFF;
        do_reset();
        tick(1);
        btn_sel = 4'b1000;
        tick(7);
        rst = 1'b1;
        expect_out("pre_reset_run", 0, 0, pk(3, 4'b1000, 1, 0, 0, 0));
        expect_out("mid_run_reset", 0, 1, ZERO);
        tick(2);
        rst     = 1'b0;
        btn_sel = 4'b0000;

        // Watchdog: 8-cycle build faults, disabled build keeps running.
        do_reset();
        tick(1);
        btn_sel = 4'b0100;
        expect_out("to_last_active",  1, 10, pk(2, 4'b0100, 1, 0, 0, 0));
        expect_out("to_fault",        1, 11, pk(2, 4'b0000, 0, 0, 0, 1));
        expect_out("to_fault_sticky", 1, 40, pk(2, 4'b0000, 0, 0, 0, 1));
        for (int k = 0; k <= 10; k++) begin
            expect_out("no_timeout_run", 2, 11 + k * 1000, pk(2, 4'b0100, 1, 0, 0, 0));
        end
        tick(10020);
        btn_abort = 1'b1;
        expect_out("to_abort_idle",  1, 2, ZERO);
        expect_out("nto_abort_idle", 2, 2, ZERO);
        tick(4);
        btn_abort = 1'b0;
        btn_sel   = 4'b0000;

        // Two-channel build: channel 1 completes on code 5.
        target   = 16'hFF5F;
        state_in = 16'h0000;
        do_reset();
        tick(1);
        btn_sel = 4'b0010;
        expect_out("n2_arm", 3, 2, pk(1, 4'b0010, 1, 0, 0, 0));
        tick(4);
        state_in[7:4] = 4'h5;
        expect_out("n2_done",      3, 2, pk(1, 4'b0000, 0, 1, 1, 0));
        expect_out("n2_done_hold", 3, 3, pk(1, 4'b0000, 0, 1, 0, 0));
        tick(5);
        btn_abort = 1'b1;
        expect_out("n2_idle", 3, 2, ZERO);
        tick(4);
        btn_abort = 1'b0;

        tick(3);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
